// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and sequencing controller for the three-stage fetch/execute/write
//   core. It drives the operand forwarding selects, the pipeline-register
//   holds, bubble insertion and the branch flush. It also holds the pipeline
//   while a data-memory read is outstanding, and keeps a saturating count of
//   PC-stall cycles.
//
// Parameters
//   BRANCH_PENALTY  cycles fe_flush stays high after a taken branch (1..3)
//   CNT_W           width of stall_cycles
//
// Ports
//   clk, reset                    core clock, async active-high reset
//   f_valid, f_rs1/2, f_use_rs1/2 fetch-stage instruction and its sources
//   e_valid, e_rd, e_writes,      execute-stage instruction
//   e_is_load, branch_taken
//   mem_ready                     data-memory read data valid this cycle
//   w_rd, w_writes                write-stage destination
//   fwd_rs1/2                     00 bank, 01 execute result, 10 write data
//   pc_stall, fe_stall, ew_stall  holds for PC, F->E and E->W registers
//   fe_bubble, fe_flush           NOP into F->E, kill fetch / redirect PC
//   stall_cycles                  saturating count of pc_stall cycles
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; branch, memory wait and load-use decided here
// FLUSH    | extra wrong-path flush cycles, fcnt counts down to 1
// MEM_WAIT | load in execute waiting for mem_ready, whole pipe held

module pipeline_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_valid,
  input  logic [4:0]       f_rs1,
  input  logic [4:0]       f_rs2,
  input  logic             f_use_rs1,
  input  logic             f_use_rs2,
  input  logic             e_valid,
  input  logic [4:0]       e_rd,
  input  logic             e_writes,
  input  logic             e_is_load,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic [4:0]       w_rd,
  input  logic             w_writes,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic             pc_stall,
  output logic             fe_stall,
  output logic             ew_stall,
  output logic             fe_bubble,
  output logic             fe_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [1:0]       FCNT_INIT = 2'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_nxt;
  logic [1:0] fcnt, fcnt_nxt;
  logic       e_fwd_ok;
  logic       lu;

  // A load's result is not available in execute, so only ALU writers forward
  // from there; the load's data is picked up from write one cycle later.
  assign e_fwd_ok = e_valid & e_writes & ~e_is_load;

  always_comb begin
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    if (!reset) begin
      if (e_fwd_ok && e_rd == f_rs1 && f_rs1 != 5'd0)
        fwd_rs1 = 2'b01;
      else if (w_writes && w_rd == f_rs1 && f_rs1 != 5'd0)
        fwd_rs1 = 2'b10;
      if (e_fwd_ok && e_rd == f_rs2 && f_rs2 != 5'd0)
        fwd_rs2 = 2'b01;
      else if (w_writes && w_rd == f_rs2 && f_rs2 != 5'd0)
        fwd_rs2 = 2'b10;
    end
  end

  assign lu = f_valid & e_valid & e_is_load & (e_rd != 5'd0) &
              ((f_use_rs1 & (e_rd == f_rs1)) | (f_use_rs2 & (e_rd == f_rs2)));

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    pc_stall  = 1'b0;
    fe_stall  = 1'b0;
    ew_stall  = 1'b0;
    fe_bubble = 1'b0;
    fe_flush  = 1'b0;
    if (reset) begin
      // Keep the fetch stage dead while the core is held in reset.
      fe_flush  = 1'b1;
      fe_bubble = 1'b1;
      state_nxt = RUN;
      fcnt_nxt  = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (e_valid && branch_taken) begin
            // Any load-use on the fetched instruction is moot: it is wrong-path.
            fe_flush  = 1'b1;
            fe_bubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FCNT_INIT;
            end
          end else if (e_valid && e_is_load && !mem_ready) begin
            pc_stall  = 1'b1;
            fe_stall  = 1'b1;
            ew_stall  = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (lu) begin
            pc_stall  = 1'b1;
            fe_bubble = 1'b1;
          end
        end
        FLUSH: begin
          fe_flush  = 1'b1;
          fe_bubble = 1'b1;
          if (fcnt <= 2'd1) begin
            fcnt_nxt  = 2'd0;
            state_nxt = RUN;
          end else begin
            fcnt_nxt = fcnt - 2'd1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            pc_stall = 1'b1;
            fe_stall = 1'b1;
            ew_stall = 1'b1;
          end else begin
            state_nxt = RUN;
            if (lu) begin
              pc_stall  = 1'b1;
              fe_bubble = 1'b1;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      fcnt         <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (pc_stall && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       f_valid, f_use_rs1, f_use_rs2;
  logic [4:0] f_rs1, f_rs2, e_rd, w_rd;
  logic       e_valid, e_writes, e_is_load, branch_taken, mem_ready, w_writes;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       pc_stall, fe_stall, ew_stall, fe_bubble, fe_flush;
  logic [3:0] stall_cycles;

  pipeline_ctrl #(.BRANCH_PENALTY(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_rs1(f_rs1), .f_rs2(f_rs2),
    .f_use_rs1(f_use_rs1), .f_use_rs2(f_use_rs2),
    .e_valid(e_valid), .e_rd(e_rd), .e_writes(e_writes),
    .e_is_load(e_is_load), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .w_rd(w_rd), .w_writes(w_writes),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .pc_stall(pc_stall), .fe_stall(fe_stall), .ew_stall(ew_stall),
    .fe_bubble(fe_bubble), .fe_flush(fe_flush),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // ctl = {pc_stall, fe_stall, ew_stall, fe_bubble, fe_flush}
  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] f1;
    logic [1:0] f2;
    logic [4:0] ctl;
    logic [3:0] sc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every negedge, check whatever the stimulus side queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_assert++;
        n_fail++;
        $display("FAIL %s: entry for cycle %0d not checked, now %0d", e.name, e.cyc, cyc);
      end else begin
        chk({e.name, ".fwd1"}, {6'd0, fwd_rs1}, {6'd0, e.f1});
        chk({e.name, ".fwd2"}, {6'd0, fwd_rs2}, {6'd0, e.f2});
        chk({e.name, ".ctl"},
            {3'd0, pc_stall, fe_stall, ew_stall, fe_bubble, fe_flush},
            {3'd0, e.ctl});
        chk({e.name, ".stall_cycles"}, {4'd0, stall_cycles}, {4'd0, e.sc});
      end
    end
  end

  task automatic push_exp(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                          input logic [4:0] ctl, input logic [3:0] sc);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.f1 = f1; e.f2 = f2; e.ctl = ctl; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_valid = 0; f_rs1 = 0; f_rs2 = 0; f_use_rs1 = 0; f_use_rs2 = 0;
    e_valid = 0; e_rd = 0; e_writes = 0; e_is_load = 0; branch_taken = 0;
    mem_ready = 1; w_rd = 0; w_writes = 0;
  endtask

  task automatic load_in_e(input logic [4:0] rd, input logic rdy);
    e_valid = 1; e_is_load = 1; e_writes = 1; e_rd = rd; mem_ready = rdy;
  endtask

  initial begin
    idle();
    // reset: outputs forced even with forwarding inputs present
    step();
    e_valid = 1; e_writes = 1; e_rd = 3; f_rs1 = 3; f_use_rs1 = 1;
    push_exp("rst", 2'b00, 2'b00, 5'b00011, 4'd0);
    step(); reset = 0; idle();
    push_exp("idle", 2'b00, 2'b00, 5'b00000, 4'd0);

    // forwarding
    step(); idle();
    f_valid = 1; e_valid = 1; e_writes = 1; e_rd = 3; w_writes = 1; w_rd = 3;
    f_rs1 = 3; f_use_rs1 = 1; f_rs2 = 0;
    push_exp("fwd_e_wins", 2'b01, 2'b00, 5'b00000, 4'd0);
    step(); e_valid = 0;
    push_exp("fwd_w", 2'b10, 2'b00, 5'b00000, 4'd0);
    step(); f_rs1 = 0; f_rs2 = 3;
    push_exp("fwd_r0", 2'b00, 2'b10, 5'b00000, 4'd0);
    step(); idle();
    f_valid = 1; load_in_e(5'd3, 1'b1); w_writes = 1; w_rd = 3; f_rs1 = 3;
    push_exp("fwd_load_skip", 2'b10, 2'b00, 5'b00000, 4'd0);

    // load-use
    step(); idle();
    f_valid = 1; load_in_e(5'd5, 1'b1); f_rs2 = 5; f_use_rs2 = 1;
    push_exp("lu_stall", 2'b00, 2'b00, 5'b10010, 4'd0);
    step(); idle();
    f_valid = 1; f_rs2 = 5; f_use_rs2 = 1; w_rd = 5; w_writes = 1;
    push_exp("lu_after", 2'b00, 2'b10, 5'b00000, 4'd1);
    step(); idle();
    push_exp("lu_idle", 2'b00, 2'b00, 5'b00000, 4'd1);

    // taken branch with simultaneous load-use
    step(); idle();
    f_valid = 1; load_in_e(5'd5, 1'b1); branch_taken = 1; f_rs2 = 5; f_use_rs2 = 1;
    push_exp("br_1", 2'b00, 2'b00, 5'b00011, 4'd1);
    step(); branch_taken = 0;
    push_exp("br_2", 2'b00, 2'b00, 5'b00011, 4'd1);
    step(); idle();
    push_exp("br_done", 2'b00, 2'b00, 5'b00000, 4'd1);

    // memory wait: 3 cycles of mem_ready=0
    step(); reset = 1; idle();
    push_exp("rst2", 2'b00, 2'b00, 5'b00011, 4'd0);
    step(); reset = 0;
    f_valid = 1; f_rs1 = 2; f_use_rs1 = 1; load_in_e(5'd6, 1'b0);
    push_exp("mw_0", 2'b00, 2'b00, 5'b11100, 4'd0);
    step();
    push_exp("mw_1", 2'b00, 2'b00, 5'b11100, 4'd1);
    step();
    push_exp("mw_2", 2'b00, 2'b00, 5'b11100, 4'd2);
    step(); mem_ready = 1;
    push_exp("mw_done", 2'b00, 2'b00, 5'b00000, 4'd3);
    step(); idle();
    push_exp("mw_idle", 2'b00, 2'b00, 5'b00000, 4'd3);

    // memory wait ending on a load-use cycle
    step(); idle();
    f_valid = 1; f_rs1 = 7; f_use_rs1 = 1; load_in_e(5'd7, 1'b0);
    push_exp("mwlu_0", 2'b00, 2'b00, 5'b11100, 4'd3);
    step(); mem_ready = 1;
    push_exp("mwlu_exit", 2'b00, 2'b00, 5'b10010, 4'd4);
    step(); idle();
    f_valid = 1; f_rs1 = 7; f_use_rs1 = 1; w_rd = 7; w_writes = 1;
    push_exp("mwlu_after", 2'b10, 2'b00, 5'b00000, 4'd5);

    // reset asserted mid memory wait, between clock edges
    step(); idle(); load_in_e(5'd6, 1'b0);
    push_exp("rm_0", 2'b00, 2'b00, 5'b11100, 4'd5);
    step();
    push_exp("rm_1", 2'b00, 2'b00, 5'b11100, 4'd6);
    step(); #2 reset = 1;
    push_exp("rm_reset", 2'b00, 2'b00, 5'b00011, 4'd0);
    step(); reset = 0; idle(); mem_ready = 0;
    push_exp("rm_run", 2'b00, 2'b00, 5'b00000, 4'd0);

    // saturation of the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      step(); idle(); load_in_e(5'd9, 1'b0);
      push_exp("sat", 2'b00, 2'b00, 5'b11100, (k > 15) ? 4'd15 : 4'(k));
    end
    step(); mem_ready = 1;
    push_exp("sat_end", 2'b00, 2'b00, 5'b00000, 4'd15);
    step(); idle();
    push_exp("sat_hold", 2'b00, 2'b00, 5'b00000, 4'd15);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
